fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYC, default 16, maximum FETCH cycles without imem_ack; used only when FETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  read address; always equals pc.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 instr_valid  output  1  instr holds an instruction for decode.
REQ-010 instr  output  32  registered instruction word.
REQ-011 instr_ready  input  1  decode accepts instr; sel, immd16 and immd26 are valid in the same cycle.
REQ-012 sel  input  2  next-PC select: 0 NextIns, 1 RelJmp, 2 AbsJmp, 3 HALT.
REQ-013 immd16  input  16  relative branch offset, in words.
REQ-014 immd26  input  26  absolute jump target, in words.
REQ-015 resume  input  1  leave HALTED.
REQ-016 pc  output  32  address of the current instruction.
REQ-017 halted  output  1  high while in HALTED.
REQ-018 issue_cnt  output  32  count of accepted instructions.
REQ-019 fetch_err  output  1  sticky fetch timeout flag.

Function
REQ-020 The FSM SHALL have four states: RESET_IDLE, FETCH, ISSUE, HALTED.
REQ-021 RESET_IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-022 In FETCH, imem_req SHALL be 1 and the FSM SHALL wait for imem_ack.
- On imem_ack: instr is loaded from imem_rdata and the FSM goes to ISSUE.
- Fetch latency from entering FETCH with a same-cycle ack SHALL be 1 cycle to instr_valid.
REQ-023 imem_req SHALL be 0 in every state other than FETCH; imem_ack outside FETCH SHALL be ignored.
REQ-024 In ISSUE, instr_valid SHALL be 1; instr and pc SHALL stay stable until instr_valid && instr_ready.
REQ-025 On the ISSUE handshake, pc SHALL update and issue_cnt SHALL increment by 1 (wrapping at 2^32), as follows:
- sel 0: pc+4.
- sel 1: pc+4+(sign-extended immd16 << 2).
- sel 2: {pc[31:28], immd26, 2'b00}.
- sel 3: pc unchanged.
REQ-026 After the ISSUE handshake, the FSM SHALL go to FETCH for sel 0-2 and to HALTED for sel 3.
REQ-027 All PC arithmetic SHALL be modulo 2^32 (e.g. 32'hFFFF_FFFC + 4 = 0).
REQ-028 In HALTED, halted SHALL be 1 and the controller SHALL issue no fetches.
- resume=1 SHALL set pc to pc+4 and go to FETCH.
- resume in any other state SHALL be ignored.
REQ-029 The sel, immd16 and immd26 inputs SHALL be sampled only on the ISSUE handshake cycle.

Reset
REQ-030 When RST=1 on a clock edge, the block SHALL set:
- state to RESET_IDLE and pc to RESET_PC;
- instr to 0 and issue_cnt to 0;
- fetch_err to 0 and the timeout counter to 0.
REQ-031 During reset, imem_req, instr_valid and halted SHALL be 0 from the cycle after the reset edge.
REQ-032 RST SHALL take priority over every other input, including imem_ack, instr_ready and resume, in any state.
- A reset mid-FETCH abandons the request; a late imem_ack is ignored.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN enables the fetch timeout.
- Defined: a counter clears on entry to FETCH and increments each FETCH cycle without imem_ack.
- When the counter reaches TIMEOUT_CYC, fetch_err SHALL be set and the FSM SHALL go to HALTED with pc unchanged.
- resume then retries at pc+4.
- Not defined: no counter exists, FETCH waits indefinitely, and fetch_err SHALL be tied to 0.

Verification
REQ-034 Reset, then ack every fetch with instr_ready=1 and sel=0 for 3 instructions.
- imem_addr SHALL be 0, 4, 8.
- issue_cnt SHALL be 3.
REQ-035 At pc=32'h0000_0010, issue with sel=1 and immd16=16'hFFFE.
- The next imem_addr SHALL be 32'h0000_000C.
- With immd16=16'h0003 instead, it SHALL be 32'h0000_0020.
REQ-036 At pc=32'h3000_0008, issue with sel=2 and immd26=26'h0000100.
- The next imem_addr SHALL be 32'h3000_0400.
REQ-037 Issue with sel=3 at pc=8.
- halted SHALL be 1, imem_req SHALL be 0 for 10 cycles and pc SHALL stay 8.
- A resume pulse SHALL then produce a fetch at 32'h0000_000C.
REQ-038 Hold instr_ready=0 for 5 cycles in ISSUE.
- instr and pc SHALL stay stable; issue_cnt SHALL be unchanged.
- Assert RST mid-FETCH with imem_ack in the same cycle: pc SHALL be RESET_PC and instr_valid SHALL stay 0.
REQ-039 With FETCH_TIMEOUT_EN defined and imem_ack held at 0:
- fetch_err and halted SHALL assert after 16 FETCH cycles.
- Without the macro, imem_req SHALL stay 1 for more than 100 cycles.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller.
// Fetches one instruction word at a time, presents it to decode, and
// updates the PC from the next-PC select (sequential, relative branch,
// absolute jump, halt) on each decode handshake.
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a fetch that
// goes TIMEOUT_CYC cycles without imem_ack raises a sticky fetch_err and
// parks the controller in HALTED. Without the macro, FETCH waits
// indefinitely and fetch_err is tied low.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    input  logic [1:0]  sel,
    input  logic [15:0] immd16,
    input  logic [25:0] immd26,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] issue_cnt,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        RESET_IDLE = 2'd0,
        FETCH      = 2'd1,
        ISSUE      = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] instr_reg;
    logic [31:0] issue_cnt_reg;
    logic        imem_req_reg;
    logic        instr_valid_reg;
    logic        halted_reg;

    // Candidate next-PC values; all arithmetic wraps modulo 2^32.
    logic [31:0] pc_plus4;
    logic [31:0] rel_offset;
    logic [31:0] rel_target;
    logic [31:0] abs_target;

    assign pc_plus4   = pc_reg + 32'd4;
    assign rel_offset = {{14{immd16[15]}}, immd16, 2'b00};
    assign rel_target = pc_plus4 + rel_offset;
    assign abs_target = {pc_reg[31:28], immd26, 2'b00};

    // Next-PC select, only consumed on the decode handshake.
    always_comb begin
        pc_next = pc_reg;
        case (sel)
            2'd0:    pc_next = pc_plus4;
            2'd1:    pc_next = rel_target;
            2'd2:    pc_next = abs_target;
            default: pc_next = pc_reg;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    // The counter only needs to reach TIMEOUT_CYC-1: the miss that would make
    // it TIMEOUT_CYC is the one that halts, so the final value is never stored.
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            fetch_err_reg;

    assign fetch_err = fetch_err_reg;
`else
    assign fetch_err = 1'b0;
`endif

    // Main controller FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg       <= RESET_IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= 32'd0;
            issue_cnt_reg   <= 32'd0;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt_reg      <= '0;
            fetch_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                RESET_IDLE: begin
                    state_reg    <= FETCH;
                    imem_req_reg <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    to_cnt_reg   <= '0;
`endif
                end

                FETCH: begin
                    if (imem_ack) begin
                        instr_reg       <= imem_rdata;
                        state_reg       <= ISSUE;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (to_cnt_reg == TO_LAST) begin
                        // Give up on this fetch; pc is left pointing at it.
                        fetch_err_reg <= 1'b1;
                        state_reg     <= HALTED;
                        imem_req_reg  <= 1'b0;
                        halted_reg    <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
`endif
                end

                ISSUE: begin
                    if (instr_ready) begin
                        pc_reg          <= pc_next;
                        issue_cnt_reg   <= issue_cnt_reg + 32'd1;
                        instr_valid_reg <= 1'b0;
                        if (sel == 2'd3) begin
                            state_reg  <= HALTED;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg    <= FETCH;
                            imem_req_reg <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                            to_cnt_reg   <= '0;
`endif
                        end
                    end
                end

                HALTED: begin
                    if (resume) begin
                        // Resume skips the halting (or timed-out) word.
                        pc_reg       <= pc_plus4;
                        state_reg    <= FETCH;
                        halted_reg   <= 1'b0;
                        imem_req_reg <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        to_cnt_reg   <= '0;
`endif
                    end
                end

                default: begin
                    state_reg <= RESET_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_reg;
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign halted      = halted_reg;
    assign issue_cnt   = issue_cnt_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic for fetch_ctrl,
// checked every cycle against a transaction-level model of the controller.
// Compile with +define+FETCH_TIMEOUT_EN to exercise the timeout build.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TCYC   = 16;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ready = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] immd16 = 16'd0;
    logic [25:0] immd26 = 26'd0;
    logic        resume = 1'b0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] issue_cnt;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .sel(sel), .immd16(immd16), .immd26(immd26),
        .resume(resume), .pc(pc), .halted(halted),
        .issue_cnt(issue_cnt), .fetch_err(fetch_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model phases: booting, waiting on memory, showing a word, stopped.
    localparam int M_BOOT = 0, M_WAIT = 1, M_SHOW = 2, M_STOP = 3;

    typedef struct {
        bit          live;
        int          mode;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
        logic        err;
        int          miss;
    } mstate_t;

    mstate_t m = '{live: 1'b0, mode: M_BOOT, pc: 32'd0, instr: 32'd0, cnt: 32'd0, err: 1'b0, miss: 0};

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t n = s;
        if (RST) begin
            n.live = 1'b1; n.mode = M_BOOT; n.pc = RST_PC; n.instr = 32'd0;
            n.cnt = 32'd0; n.err = 1'b0; n.miss = 0;
            return n;
        end
        if (!s.live) return n;
        case (s.mode)
            M_BOOT: begin n.mode = M_WAIT; n.miss = 0; end
            M_WAIT: begin
                if (imem_ack) begin
                    n.instr = imem_rdata;
                    n.mode  = M_SHOW;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    n.miss = s.miss + 1;
                    if (n.miss >= TCYC) begin
                        n.err  = 1'b1;
                        n.mode = M_STOP;
                    end
`endif
                end
            end
            M_SHOW: begin
                if (instr_ready) begin
                    n.cnt = s.cnt + 32'd1;
                    case (sel)
                        2'd0: n.pc = s.pc + 32'd4;
                        2'd1: n.pc = s.pc + 32'd4 + 32'(int'($signed(immd16)) * 4);
                        2'd2: n.pc = (s.pc & 32'hF000_0000) + 32'(immd26) * 32'd4;
                        default: n.pc = s.pc;
                    endcase
                    n.mode = (sel == 2'd3) ? M_STOP : M_WAIT;
                    n.miss = 0;
                end
            end
            default: begin
                if (resume) begin
                    n.pc   = s.pc + 32'd4;
                    n.mode = M_WAIT;
                    n.miss = 0;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m);

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m.live) begin
            check("cyc_imem_req",    32'(imem_req),    32'(m.mode == M_WAIT));
            check("cyc_imem_addr",   imem_addr,        m.pc);
            check("cyc_pc",          pc,               m.pc);
            check("cyc_instr_valid", 32'(instr_valid), 32'(m.mode == M_SHOW));
            check("cyc_instr",       instr,            m.instr);
            check("cyc_halted",      32'(halted),      32'(m.mode == M_STOP));
            check("cyc_issue_cnt",   issue_cnt,        m.cnt);
            check("cyc_fetch_err",   32'(fetch_err),   32'(m.err));
        end
    end

    // ---------------- directed helpers ----------------
    function automatic logic dut_flag(input int which);
        case (which)
            0:       return imem_req;
            1:       return instr_valid;
            default: return halted;
        endcase
    endfunction

    task automatic wait_for(input string what, input int which, input int limit);
        int n = 0;
        while (dut_flag(which) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (dut_flag(which) !== 1'b1) begin
            n_errors++;
            $display("FAIL wait_%s: not high after %0d cycles, required within %0d", what, n, limit);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; resume = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
    endtask

    // One full fetch + issue; returns the address the fetch was made at.
    task automatic run_instr(input logic [1:0] s, input logic [15:0] i16,
                             input logic [25:0] i26, output logic [31:0] faddr);
        wait_for("req", 0, 50);
        faddr = imem_addr;
        imem_ack = 1'b1; imem_rdata = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
        wait_for("valid", 1, 50);
        instr_ready = 1'b1; sel = s; immd16 = i16; immd26 = i26;
        @(negedge clk);
        instr_ready = 1'b0;
        sel = 2'($urandom); immd16 = 16'($urandom); immd26 = 26'($urandom);
    endtask

    logic [31:0] a;
    logic [31:0] hold_instr, hold_pc, hold_cnt;
    int          n;

    initial begin
        @(negedge clk);
        do_reset();
        // reset state
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_issue_cnt", issue_cnt, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'h0);

        // three sequential instructions
        for (int i = 0; i < 3; i++) begin
            run_instr(2'd0, 16'd0, 26'd0, a);
            check("seq_addr", a, 32'(i * 4));
        end
        check("seq_issue_cnt", issue_cnt, 32'd3);

        // relative branches from pc=0x10
        run_instr(2'd0, 16'd0, 26'd0, a);            // at 0xC -> 0x10
        run_instr(2'd1, 16'hFFFE, 26'd0, a);         // at 0x10, back
        check("rel_at", a, 32'h10);
        run_instr(2'd0, 16'd0, 26'd0, a);
        check("rel_back_addr", a, 32'h0000_000C);
        run_instr(2'd1, 16'h0003, 26'd0, a);         // at 0x10, forward
        run_instr(2'd0, 16'd0, 26'd0, a);
        check("rel_fwd_addr", a, 32'h0000_0020);

        // absolute jump to 8, then halt there
        run_instr(2'd2, 16'd0, 26'h2, a);
        run_instr(2'd3, 16'd0, 26'd0, a);
        check("halt_at", a, 32'h8);
        for (int k = 0; k < 10; k++) begin
            imem_ack = ($urandom_range(0, 1) == 1);
            check("halt_halted", 32'(halted), 32'h1);
            check("halt_req", 32'(imem_req), 32'h0);
            check("halt_pc", pc, 32'h8);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        wait_for("req", 0, 10);
        check("resume_addr", imem_addr, 32'h0000_000C);

        // stall in ISSUE
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0;
        hold_instr = instr; hold_pc = pc; hold_cnt = issue_cnt;
        check("stall_instr_loaded", instr, 32'hCAFE_F00D);
        for (int k = 0; k < 5; k++) begin
            sel = 2'($urandom); immd16 = 16'($urandom);
            @(negedge clk);
            check("stall_instr", instr, hold_instr);
            check("stall_pc", pc, hold_pc);
            check("stall_cnt", issue_cnt, hold_cnt);
            check("stall_valid", 32'(instr_valid), 32'h1);
        end
        instr_ready = 1'b1; sel = 2'd0;
        @(negedge clk);
        instr_ready = 1'b0;

        // reset mid-FETCH with a same-cycle ack
        check("midrst_in_fetch", 32'(imem_req), 32'h1);
        RST = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("midrst_pc", pc, RST_PC);
        check("midrst_valid", 32'(instr_valid), 32'h0);
        check("midrst_instr", instr, 32'h0);
        RST = 1'b0;                                  // ack still high: ignored in idle
        @(negedge clk);
        check("midrst_valid2", 32'(instr_valid), 32'h0);
        check("midrst_req", 32'(imem_req), 32'h1);
        imem_ack = 1'b0;
        @(negedge clk);
        check("midrst_valid3", 32'(instr_valid), 32'h0);

        // PC wrap-around
        run_instr(2'd1, 16'hFFFE, 26'd0, a);         // 0 -> 0xFFFFFFFC
        run_instr(2'd0, 16'd0, 26'd0, a);
        check("wrap_top", a, 32'hFFFF_FFFC);
        wait_for("req", 0, 10);
        check("wrap_zero", imem_addr, 32'h0);

        // fetch with no ack
`ifdef FETCH_TIMEOUT_EN
        n = 0;
        while (imem_req === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 32'(n), 32'(TCYC));
        check("to_halted", 32'(halted), 32'h1);
        check("to_fetch_err", 32'(fetch_err), 32'h1);
        check("to_pc", pc, 32'h0);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        wait_for("req", 0, 10);
        check("to_retry_addr", imem_addr, 32'h4);
        check("to_err_sticky", 32'(fetch_err), 32'h1);
`else
        for (int k = 0; k < 101; k++) begin
            check("noto_req", 32'(imem_req), 32'h1);
            @(negedge clk);
        end
        check("noto_fetch_err", 32'(fetch_err), 32'h0);
`endif

        // climb to 0x3000_0000 with maximal forward branches, then jump
        do_reset();
        for (int k = 0; k < 6144; k++) run_instr(2'd1, 16'h7FFF, 26'd0, a);
        wait_for("req", 0, 10);
        check("climb_addr", imem_addr, 32'h3000_0000);
        run_instr(2'd0, 16'd0, 26'd0, a);
        run_instr(2'd0, 16'd0, 26'd0, a);
        run_instr(2'd2, 16'd0, 26'h0000100, a);
        check("abs_at", a, 32'h3000_0008);
        wait_for("req", 0, 10);
        check("abs_addr", imem_addr, 32'h3000_0400);

        // randomized traffic, model-checked every cycle
        for (int c = 0; c < 4000; c++) begin
            RST         = ($urandom_range(0, 79) == 0);
            imem_ack    = (c < 2000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            imem_rdata  = $urandom;
            instr_ready = ($urandom_range(0, 1) == 1);
            sel         = 2'($urandom);
            immd16      = 16'($urandom);
            immd26      = 26'($urandom);
            resume      = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        RST = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; resume = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
